// File: rtl/pipe_cond_unit_pkg.sv
// Shared pipeline definitions: condition-code encodings and flag bit positions.
// Imported by the condition evaluator and the Execute/Memory control logic.
package pipe_cond_unit_pkg;

    localparam int FLAGS_W = 4;

    // Bit positions inside the architectural {N,Z,C,V} flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/pipe_cond_check.sv
// Purely combinational condition evaluator: maps a condition field and the
// current {N,Z,C,V} flags to a pass/fail bit.
module pipe_cond_check
    import pipe_cond_unit_pkg::*;
(
    input  logic [3:0]         cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            // NV is never-execute, so it must block every side effect
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_cond_unit.sv
// Execute-stage conditional unit: gates E-stage controls by the condition
// result, owns the architectural flag register and the E/M control register.
module pipe_cond_unit
    import pipe_cond_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         CondE,
    input  logic [1:0]         FlagWE,
    input  logic [FLAGS_W-1:0] ALUFlags,
    input  logic               PCSrcE,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic               BranchE,
    input  logic               NoWriteE,
    input  logic               FlushE,
    input  logic               StallM,
    output logic               CondExE,
    output logic               BranchTakenE,
    output logic               PCSrcM,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic [FLAGS_W-1:0] FlagsQ
);

    logic               cond_pass_p0;
    logic               cond_ex_p0;
    logic               pcsrc_d_p0;
    logic               regwrite_d_p0;
    logic               memwrite_d_p0;
    logic               wr_nz_p0;
    logic               wr_cv_p0;

    logic [FLAGS_W-1:0] flags_p1;
    logic               pcsrc_p1;
    logic               regwrite_p1;
    logic               memwrite_p1;

    // Evaluation reads only the registered flags, never ALUFlags directly
    pipe_cond_check u_cond_check (
        .cond    (CondE),
        .flags   (flags_p1),
        .cond_ex (cond_pass_p0)
    );

    // ---- Execute stage (combinational gating) ----
    assign cond_ex_p0    = cond_pass_p0 & ~FlushE;
    assign pcsrc_d_p0    = PCSrcE & cond_ex_p0;
    assign regwrite_d_p0 = RegWriteE & cond_ex_p0 & ~NoWriteE;
    assign memwrite_d_p0 = MemWriteE & cond_ex_p0;
    assign wr_nz_p0      = FlagWE[1] & cond_ex_p0;
    assign wr_cv_p0      = FlagWE[0] & cond_ex_p0;

    assign CondExE       = cond_ex_p0;
    assign BranchTakenE  = BranchE & cond_ex_p0;

    // ---- Execute -> Memory register boundary ----
    // A stall freezes the flags too, so a held instruction cannot update them twice.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_p1    <= '0;
            pcsrc_p1    <= 1'b0;
            regwrite_p1 <= 1'b0;
            memwrite_p1 <= 1'b0;
        end else if (!StallM) begin
            pcsrc_p1    <= pcsrc_d_p0;
            regwrite_p1 <= regwrite_d_p0;
            memwrite_p1 <= memwrite_d_p0;
            if (wr_nz_p0) begin
                flags_p1[FLAG_N] <= ALUFlags[FLAG_N];
                flags_p1[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (wr_cv_p0) begin
                flags_p1[FLAG_C] <= ALUFlags[FLAG_C];
                flags_p1[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    assign FlagsQ    = flags_p1;
    assign PCSrcM    = pcsrc_p1;
    assign RegWriteM = regwrite_p1;
    assign MemWriteM = memwrite_p1;

endmodule

// File: tb/tb_pipe_cond_unit.sv
// Bench for pipe_cond_unit: directed scenarios plus random traffic, all checked
// against a behavioural model of flags and the Memory-stage controls.
module tb_pipe_cond_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] CondE;
    logic [1:0] FlagWE;
    logic [3:0] ALUFlags;
    logic       PCSrcE, RegWriteE, MemWriteE, BranchE, NoWriteE, FlushE, StallM;
    logic       CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM;
    logic [3:0] FlagsQ;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [3:0] m_flags;
    logic       m_pcsrc, m_regw, m_memw;

    pipe_cond_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .CondE        (CondE),
        .FlagWE       (FlagWE),
        .ALUFlags     (ALUFlags),
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .BranchE      (BranchE),
        .NoWriteE     (NoWriteE),
        .FlushE       (FlushE),
        .StallM       (StallM),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .PCSrcM       (PCSrcM),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .FlagsQ       (FlagsQ)
    );

    always #5 clk = ~clk;

    // Even codes test a base predicate, odd codes are its complement; 14/15 fixed.
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (code == 4'd14) return 1'b1;
        if (code == 4'd15) return 1'b0;
        case (code >> 1)
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ code[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One instruction cycle: drive, check combinational outputs, clock, check state.
    task automatic step(input logic rst_n, input logic [3:0] cond, input logic [1:0] fwe,
                        input logic [3:0] alu, input logic pcs, input logic rw,
                        input logic mw, input logic br, input logic nw,
                        input logic fl, input logic st, input string tag);
        logic cex;
        reset_n = rst_n; CondE = cond; FlagWE = fwe; ALUFlags = alu;
        PCSrcE = pcs; RegWriteE = rw; MemWriteE = mw; BranchE = br;
        NoWriteE = nw; FlushE = fl; StallM = st;
        #1;
        cex = fl ? 1'b0 : ref_cond(cond, m_flags);
        chk({tag, "_condex"}, {3'b0, CondExE}, {3'b0, cex});
        chk({tag, "_brtaken"}, {3'b0, BranchTakenE}, {3'b0, br & cex});
        @(posedge clk);
        if (!rst_n) begin
            m_flags = 4'b0; m_pcsrc = 0; m_regw = 0; m_memw = 0;
        end else if (!st) begin
            m_pcsrc = pcs & cex;
            m_regw  = rw & cex & !nw;
            m_memw  = mw & cex;
            if (fwe[1] && cex) m_flags[3:2] = alu[3:2];
            if (fwe[0] && cex) m_flags[1:0] = alu[1:0];
        end
        #1;
        chk({tag, "_flags"}, FlagsQ, m_flags);
        chk({tag, "_mctl"}, {1'b0, PCSrcM, RegWriteM, MemWriteM},
            {1'b0, m_pcsrc, m_regw, m_memw});
    endtask

    initial begin
        reset_n = 0; CondE = 0; FlagWE = 0; ALUFlags = 0; PCSrcE = 0; RegWriteE = 0;
        MemWriteE = 0; BranchE = 0; NoWriteE = 0; FlushE = 0; StallM = 1;

        // Reset with stall and flush active: state still clears
        FlushE = 1;
        @(posedge clk); #1;
        m_flags = 4'b0; m_pcsrc = 0; m_regw = 0; m_memw = 0;
        chk("reset_flags", FlagsQ, 4'b0000);
        chk("reset_mctl", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0);

        // EQ during reset sees cleared flags
        step(0, 4'b0000, 2'b11, 4'b1111, 1, 1, 1, 1, 0, 0, 0, "rst_eq");
        chk("rst_eq_const", {3'b0, CondExE}, 4'b0);

        // SUBS sets Z, then EQ-conditioned write lands a cycle later
        step(1, 4'b1110, 2'b11, 4'b0100, 0, 1, 0, 0, 0, 0, 0, "subs");
        chk("subs_flags_const", FlagsQ, 4'b0100);
        step(1, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0, 0, "eq_write");
        chk("eq_write_const", {3'b0, RegWriteM}, 4'b0001);

        // CMP: no register write, flags N set; LT branch taken
        step(1, 4'b1110, 2'b11, 4'b1000, 0, 1, 0, 0, 1, 0, 0, "cmp");
        chk("cmp_const", {FlagsQ[3:1], RegWriteM}, {3'b100, 1'b0});
        step(1, 4'b1011, 2'b00, 4'b0000, 0, 0, 0, 1, 0, 0, 0, "lt_branch");

        // Independent flag halves
        step(1, 4'b1110, 2'b11, 4'b0010, 0, 0, 0, 0, 0, 0, 0, "set_0010");
        step(1, 4'b1110, 2'b10, 4'b0101, 0, 0, 0, 0, 0, 0, 0, "nz_only");
        chk("nz_only_const", FlagsQ, 4'b0110);
        step(1, 4'b1110, 2'b01, 4'b1001, 0, 0, 0, 0, 0, 0, 0, "cv_only");
        chk("cv_only_const", FlagsQ, 4'b0101);

        // Flush and stall interaction
        step(1, 4'b1110, 2'b00, 4'b0000, 1, 1, 1, 0, 0, 0, 0, "prime_m");
        step(1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 0, 1, 1, "flush_stall");
        chk("flush_stall_hold", {1'b0, PCSrcM, RegWriteM, MemWriteM}, 4'b0111);
        step(1, 4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 0, 1, 0, "flush");
        chk("flush_const", {MemWriteM, FlagsQ[2:0]}, {1'b0, 3'b101});

        // NV never executes
        step(1, 4'b1111, 2'b11, 4'b1010, 1, 1, 1, 1, 0, 0, 0, "nv");

        // Reset arriving mid-stall discards held values, then normal load
        step(1, 4'b1110, 2'b00, 4'b0000, 1, 1, 1, 0, 0, 0, 0, "pre_stall");
        step(1, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 1, "stall");
        step(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 1, "rst_in_stall");
        step(1, 4'b1110, 2'b00, 4'b0000, 1, 0, 1, 0, 0, 0, 0, "post_rst");

        // All 16 codes against all 16 flag values
        for (int f = 0; f < 16; f++) begin
            step(1, 4'b1110, 2'b11, 4'(f), 0, 0, 0, 0, 0, 0, 0, "sweep_load");
            for (int c = 0; c < 16; c++) begin
                CondE = 4'(c); FlagWE = 0; FlushE = 0; StallM = 1;
                #1;
                chk($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, CondExE},
                    {3'b0, ref_cond(4'(c), 4'(f))});
            end
        end

        // Random traffic, occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 31) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
                 r[0], r[1], r[2], r[3], 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
